// File: rtl/free_list.sv
// Circular FIFO of free physical register indices feeding rename.
// Flush reclaims every speculative allocation in one cycle by restoring rd_ptr behind wr_ptr.
module free_list #(
  parameter int PRF_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH,
  parameter int PRF_IDX_W = $clog2(PRF_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        deq_valid,
  output logic [PRF_IDX_W-1:0]        deq_idx,
  input  logic                        deq_en,
  input  logic                        enq_en,
  input  logic [PRF_IDX_W-1:0]        enq_idx,
  input  logic                        flush,
  output logic [$clog2(FL_DEPTH):0]   count
);

  localparam int AW    = $clog2(FL_DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PRF_IDX_W-1:0] r_mem [FL_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_enq_fire;
  logic                 w_deq_fire;
  logic [PTR_W-1:0]     w_wr_next;
  logic [PTR_W-1:0]     w_rd_next;

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) && (r_rd_ptr[AW] != r_wr_ptr[AW]);

  // Pop is suppressed on flush; the flush restores rd_ptr regardless.
  assign w_enq_fire = enq_en && !w_full;
  assign w_deq_fire = deq_en && !w_empty && !flush;

  assign w_wr_next = r_wr_ptr + (w_enq_fire ? PTR_W'(1) : PTR_W'(0));

  always_comb begin
    w_rd_next = r_rd_ptr + (w_deq_fire ? PTR_W'(1) : PTR_W'(0));
    // The FL_DEPTH slots behind the post-commit wr_ptr hold exactly the free set.
    if (flush) begin
      w_rd_next = {~w_wr_next[AW], w_wr_next[AW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= {1'b1, {AW{1'b0}}};
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_mem[i] <= PRF_IDX_W'(ARF_DEPTH + i);
      end
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_wr_next;
      if (w_enq_fire) begin
        r_mem[r_wr_ptr[AW-1:0]] <= enq_idx;
      end
    end
  end

  assign deq_valid = !w_empty;
  assign deq_idx   = r_mem[r_rd_ptr[AW-1:0]];
  assign count     = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(deq_en && w_empty && !flush && !enq_en))
        else $warning("free_list: deq_en while empty ignored");
      assert (!(enq_en && w_full))
        else $warning("free_list: enq_en while full ignored");
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: constant vector table, hand sequences, and random traffic
// compared against a history-of-writes model of the ring.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       deq_en;
  logic       enq_en;
  logic [5:0] enq_idx;
  logic       flush;
  logic       deq_valid;
  logic [5:0] deq_idx;
  logic [5:0] count;

  free_list dut (
    .clk(clk), .rst(rst),
    .deq_valid(deq_valid), .deq_idx(deq_idx), .deq_en(deq_en),
    .enq_en(enq_en), .enq_idx(enq_idx), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: every value ever written to the ring, in order; the free set is hist[n_pop..].
  // A flush makes the last 32 written values free again.
  int hist[$];
  int n_pop;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 32; i++) hist.push_back(32 + i);
    n_pop = 0;
  endtask

  function automatic int model_cnt();
    return hist.size() - n_pop;
  endfunction

  task automatic cycle(input logic d, input logic e, input logic [5:0] idx,
                       input logic f, input logic r);
    int c;
    deq_en = d; enq_en = e; enq_idx = idx; flush = f; rst = r;
    c = model_cnt();
    if (r) begin
      model_reset();
    end else begin
      if (d && c > 0 && !f) n_pop++;
      if (e && c < 32) hist.push_back(int'(idx));
      if (f) n_pop = hist.size() - 32;
    end
    @(posedge clk);
    #1;
    deq_en = 0; enq_en = 0; enq_idx = '0; flush = 0; rst = 0;
  endtask

  task automatic check_model(input string tag);
    int c;
    c = model_cnt();
    check({tag, "_count"}, int'(count), c);
    check({tag, "_valid"}, int'(deq_valid), (c > 0) ? 1 : 0);
    if (c > 0) check({tag, "_idx"}, int'(deq_idx), hist[n_pop]);
  endtask

  typedef struct {
    logic       d;
    logic       e;
    logic [5:0] idx;
    logic       f;
    int         cnt;
    int         v;
    int         hd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int c;
    rst = 1; deq_en = 0; enq_en = 0; enq_idx = '0; flush = 0;

    // Flush/commit scenario from reset, expectations written out by hand.
    tbl[0]  = '{1'b0, 1'b0, 6'd0,  1'b0, 32, 1, 32};
    tbl[1]  = '{1'b1, 1'b0, 6'd0,  1'b0, 31, 1, 33};
    tbl[2]  = '{1'b1, 1'b0, 6'd0,  1'b0, 30, 1, 34};
    tbl[3]  = '{1'b1, 1'b0, 6'd0,  1'b0, 29, 1, 35};
    tbl[4]  = '{1'b0, 1'b1, 6'd10, 1'b1, 32, 1, 33};
    tbl[5]  = '{1'b1, 1'b0, 6'd0,  1'b0, 31, 1, 34};
    tbl[6]  = '{1'b1, 1'b0, 6'd0,  1'b0, 30, 1, 35};
    tbl[7]  = '{1'b1, 1'b0, 6'd0,  1'b1, 32, 1, 33};
    tbl[8]  = '{1'b0, 1'b0, 6'd0,  1'b1, 32, 1, 33};
    tbl[9]  = '{1'b1, 1'b0, 6'd0,  1'b0, 31, 1, 34};
    tbl[10] = '{1'b1, 1'b1, 6'd20, 1'b0, 31, 1, 35};

    // Reset and idle.
    cycle(0, 0, 0, 0, 1);
    check("rst_count", int'(count), 32);
    check("rst_valid", int'(deq_valid), 1);
    check("rst_idx", int'(deq_idx), 32);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      check_model("idle");
    end

    // Drain all 32 in order, then an ignored pop on empty.
    for (int i = 0; i < 32; i++) begin
      check("drain_head", int'(deq_idx), 32 + i);
      cycle(1, 0, 0, 0, 0);
    end
    check("empty_valid", int'(deq_valid), 0);
    check("empty_count", int'(count), 0);
    cycle(1, 0, 0, 0, 0);
    check("ovr_deq_count", int'(count), 0);
    check("ovr_deq_valid", int'(deq_valid), 0);

    // Enq+deq on empty: no pop, the new entry appears next cycle.
    cycle(1, 1, 6'd5, 0, 0);
    check("e_count1", int'(count), 1);
    check("e_idx5", int'(deq_idx), 5);
    cycle(0, 1, 6'd7, 0, 0);
    check_model("e_enq7");
    cycle(1, 0, 0, 0, 0);
    check("e_idx7", int'(deq_idx), 7);
    cycle(1, 0, 0, 0, 0);
    check("e_count0", int'(count), 0);
    check("e_valid0", int'(deq_valid), 0);

    // Table-driven flush vectors.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].d, tbl[i].e, tbl[i].idx, tbl[i].f, 1'b0);
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      check($sformatf("tbl%0d_valid", i), int'(deq_valid), tbl[i].v);
      check($sformatf("tbl%0d_idx", i), int'(deq_idx), tbl[i].hd);
    end

    // Wrap stress: steady enq+deq at occupancy 31 across many wraps.
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle(1, 1, 6'($urandom_range(0, 63)), 0, 0);
      check_model("wrap");
    end

    // Random mixed traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      logic d, e, f;
      c = model_cnt();
      d = ($urandom_range(0, 1) == 1) && (c > 0);
      e = ($urandom_range(0, 1) == 1) && (c < 32);
      f = ($urandom_range(0, 15) == 0);
      cycle(d, e, 6'($urandom_range(0, 63)), f, 0);
      check_model("rand");
    end

    // Reset mid-operation with an enqueue pending.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, 0, 0);
    check("mid_count7", int'(count), 7);
    cycle(1, 1, 6'd9, 0, 1);
    check("mid_rst_count", int'(count), 32);
    check("mid_rst_idx", int'(deq_idx), 32);
    for (int i = 0; i < 32; i++) begin
      check("mid_image", int'(deq_idx), 32 + i);
      cycle(1, 0, 0, 0, 0);
    end
    check("mid_empty", int'(deq_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
